// File: rtl/burst_types.sv
`default_nettype none
// ============================================================================
// Module      : burst_types (package)
// Description : Shared types and default geometry for the cache-to-memory
//               burst arbiter: line/beat widths, beat count and the arbiter
//               state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package burst_types;

  // Default geometry: one 256-bit cache line moved as four 64-bit beats.
  localparam int c_LINE_W  = 256;
  localparam int c_BURST_W = 64;
  localparam int c_BEATS   = 4;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    I_RD = 3'd1,
    D_RD = 3'd2,
    D_WR = 3'd3,
    DONE = 3'd4
  } burst_state_e;

endpackage
`default_nettype wire

// File: rtl/line_burst_buffer.sv
`default_nettype none
// ============================================================================
// Module      : line_burst_buffer
// Description : Beat counter plus line assembly (read) and disassembly
//               (write) registers. Read beats are stored into the slot
//               selected by the counter; the write line is presented one beat
//               at a time. The counter wraps to zero after the last beat.
// Ports       : clk, reset_n  - clock, async active-low reset
//               i_load_wr     - capture i_wline as the line to write
//               i_wline       - writeback line
//               i_rd_beat     - store i_rbeat into current slot, advance
//               i_wr_beat     - current write beat accepted, advance
//               i_rbeat       - incoming read beat
//               o_rline       - assembled read line (held until overwritten)
//               o_wbeat       - write beat selected by the counter
//               o_last        - counter is at the final beat
// Revision    : 1.0 - initial release
// ============================================================================
module line_burst_buffer
  import burst_types::*;
#(
  parameter int LINE_W  = c_LINE_W,
  parameter int BURST_W = c_BURST_W,
  parameter int BEATS   = c_BEATS
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               i_load_wr,
  input  logic [LINE_W-1:0]  i_wline,
  input  logic               i_rd_beat,
  input  logic               i_wr_beat,
  input  logic [BURST_W-1:0] i_rbeat,
  output logic [LINE_W-1:0]  o_rline,
  output logic [BURST_W-1:0] o_wbeat,
  output logic               o_last
);

  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

  logic [CNT_W-1:0]  r_cnt;
  logic [LINE_W-1:0] r_rline;
  logic [LINE_W-1:0] r_wline;
  logic              w_last;

  assign w_last = (r_cnt == CNT_W'(BEATS - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt   <= '0;
      r_rline <= '0;
      r_wline <= '0;
    end else begin
      if (i_load_wr) begin
        r_wline <= i_wline;
      end
      if (i_rd_beat) begin
        r_rline[int'(r_cnt) * BURST_W +: BURST_W] <= i_rbeat;
      end
      if (i_rd_beat || i_wr_beat) begin
        // Explicit clear keeps the wrap correct even if BEATS is not a power of two.
        r_cnt <= w_last ? '0 : r_cnt + CNT_W'(1);
      end
    end
  end

  assign o_rline = r_rline;
  assign o_wbeat = r_wline[int'(r_cnt) * BURST_W +: BURST_W];
  assign o_last  = w_last;

endmodule
`default_nettype wire

// File: rtl/mem_burst_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_burst_arbiter
// Description : Arbitrates icache line reads and dcache line reads/writebacks
//               onto a single burst memory port. Ties are broken in favour of
//               the port not granted last; a dcache read+write is a write.
// Ports       : clk, reset_n             - clock, async active-low reset
//               i_read, i_addr           - icache line read request
//               i_rdata, i_resp          - icache line and completion pulse
//               d_read, d_write, d_addr, d_wdata - dcache request
//               d_rdata, d_resp          - dcache line and completion pulse
//               mem_read, mem_write, mem_addr, mem_wdata - memory burst
//               mem_rdata, mem_resp      - memory beat data / handshake
// Revision    : 1.0 - initial release
// ============================================================================
module mem_burst_arbiter
  import burst_types::*;
#(
  parameter int LINE_W  = c_LINE_W,
  parameter int BURST_W = c_BURST_W,
  parameter int BEATS   = c_BEATS
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               i_read,
  input  logic [31:0]        i_addr,
  output logic [LINE_W-1:0]  i_rdata,
  output logic               i_resp,
  input  logic               d_read,
  input  logic               d_write,
  input  logic [31:0]        d_addr,
  input  logic [LINE_W-1:0]  d_wdata,
  output logic [LINE_W-1:0]  d_rdata,
  output logic               d_resp,
  output logic               mem_read,
  output logic               mem_write,
  output logic [31:0]        mem_addr,
  output logic [BURST_W-1:0] mem_wdata,
  input  logic [BURST_W-1:0] mem_rdata,
  input  logic               mem_resp
);

  burst_state_e r_state;
  logic         r_last_d;     // 1: dcache was granted last, 0: icache
  logic [31:0]  r_addr;
  logic         r_mem_read;
  logic         r_mem_write;
  logic         r_i_resp;
  logic         r_d_resp;

  logic              w_d_req;
  logic              w_pick_d;
  logic              w_pick_i;
  logic              w_load_wr;
  logic              w_rd_beat;
  logic              w_wr_beat;
  logic              w_last;
  logic [LINE_W-1:0] w_rline;
  logic              w_unused_addr;

  // Line-aligned addressing: the low offset bits never reach memory.
  assign w_unused_addr = &{1'b0, i_addr[4:0], d_addr[4:0]};

  assign w_d_req  = d_read | d_write;
  // dcache wins when alone, or on a tie when icache had the last grant.
  assign w_pick_d = w_d_req && (!i_read || !r_last_d);
  assign w_pick_i = i_read && !w_pick_d;

  assign w_load_wr = (r_state == IDLE) && w_pick_d && d_write;
  assign w_rd_beat = mem_resp && ((r_state == I_RD) || (r_state == D_RD));
  assign w_wr_beat = mem_resp && (r_state == D_WR);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= IDLE;
      r_last_d    <= 1'b0;
      r_addr      <= '0;
      r_mem_read  <= 1'b0;
      r_mem_write <= 1'b0;
      r_i_resp    <= 1'b0;
      r_d_resp    <= 1'b0;
    end else begin
      r_i_resp <= 1'b0;
      r_d_resp <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_pick_d) begin
            r_addr   <= {d_addr[31:5], 5'b0};
            r_last_d <= 1'b1;
            if (d_write) begin
              r_state     <= D_WR;
              r_mem_write <= 1'b1;
            end else begin
              r_state    <= D_RD;
              r_mem_read <= 1'b1;
            end
          end else if (w_pick_i) begin
            r_addr     <= {i_addr[31:5], 5'b0};
            r_last_d   <= 1'b0;
            r_state    <= I_RD;
            r_mem_read <= 1'b1;
          end
        end
        I_RD, D_RD: begin
          if (mem_resp && w_last) begin
            r_state    <= DONE;
            r_mem_read <= 1'b0;
            r_i_resp   <= (r_state == I_RD);
            r_d_resp   <= (r_state == D_RD);
          end
        end
        D_WR: begin
          if (mem_resp && w_last) begin
            r_state     <= DONE;
            r_mem_write <= 1'b0;
            r_d_resp    <= 1'b1;
          end
        end
        // Requests still held here are deliberately ignored until IDLE.
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  line_burst_buffer #(
    .LINE_W  (LINE_W),
    .BURST_W (BURST_W),
    .BEATS   (BEATS)
  ) u_buf (
    .clk       (clk),
    .reset_n   (reset_n),
    .i_load_wr (w_load_wr),
    .i_wline   (d_wdata),
    .i_rd_beat (w_rd_beat),
    .i_wr_beat (w_wr_beat),
    .i_rbeat   (mem_rdata),
    .o_rline   (w_rline),
    .o_wbeat   (mem_wdata),
    .o_last    (w_last)
  );

  assign i_rdata   = w_rline;
  assign d_rdata   = w_rline;
  assign i_resp    = r_i_resp;
  assign d_resp    = r_d_resp;
  assign mem_read  = r_mem_read;
  assign mem_write = r_mem_write;
  assign mem_addr  = r_addr;

endmodule
`default_nettype wire

// File: tb/tb_mem_burst_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_burst_arbiter
// Description : Directed self-checking bench for mem_burst_arbiter. Inputs
//               change and outputs are checked on the falling clock edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_burst_arbiter;

  logic         clk;
  logic         reset_n;
  logic         i_read;
  logic [31:0]  i_addr;
  logic [255:0] i_rdata;
  logic         i_resp;
  logic         d_read;
  logic         d_write;
  logic [31:0]  d_addr;
  logic [255:0] d_wdata;
  logic [255:0] d_rdata;
  logic         d_resp;
  logic         mem_read;
  logic         mem_write;
  logic [31:0]  mem_addr;
  logic [63:0]  mem_wdata;
  logic [63:0]  mem_rdata;
  logic         mem_resp;

  int n_cmp = 0;
  int n_err = 0;

  mem_burst_arbiter #(
    .LINE_W  (256),
    .BURST_W (64),
    .BEATS   (4)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .i_read    (i_read),
    .i_addr    (i_addr),
    .i_rdata   (i_rdata),
    .i_resp    (i_resp),
    .d_read    (d_read),
    .d_write   (d_write),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_rdata   (d_rdata),
    .d_resp    (d_resp),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_resp  (mem_resp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  // One accepted memory beat: mem_resp high across exactly one rising edge.
  task automatic beat(input logic [63:0] rd);
    mem_resp  = 1'b1;
    mem_rdata = rd;
    @(negedge clk);
    mem_resp  = 1'b0;
  endtask

  localparam logic [63:0] B1 = 64'h1111_1111_1111_1111;
  localparam logic [63:0] B2 = 64'h2222_2222_2222_2222;
  localparam logic [63:0] B3 = 64'h3333_3333_3333_3333;
  localparam logic [63:0] B4 = 64'h4444_4444_4444_4444;

  logic [255:0] line_a;
  logic [255:0] pat_p;
  logic [255:0] pat_q;
  logic [255:0] line_d;
  logic [255:0] line_i;
  logic [255:0] line_r;

  initial begin
    line_a = {B4, B3, B2, B1};
    pat_p  = {64'hDDDD_0000_DDDD_0003, 64'hCCCC_0000_CCCC_0002,
              64'hBBBB_0000_BBBB_0001, 64'hAAAA_0000_AAAA_0000};
    pat_q  = {64'h0F0F_0F0F_0000_0004, 64'h0E0E_0E0E_0000_0003,
              64'h0D0D_0D0D_0000_0002, 64'h0C0C_0C0C_0000_0001};
    line_d = {64'hD400_0000_0000_00D4, 64'hD300_0000_0000_00D3,
              64'hD200_0000_0000_00D2, 64'hD100_0000_0000_00D1};
    line_i = {64'hE400_0000_0000_00E4, 64'hE300_0000_0000_00E3,
              64'hE200_0000_0000_00E2, 64'hE100_0000_0000_00E1};
    line_r = {64'h5A5A_0000_0000_0004, 64'h5A5A_0000_0000_0003,
              64'h5A5A_0000_0000_0002, 64'h5A5A_0000_0000_0001};

    reset_n = 1'b0; i_read = 1'b0; i_addr = '0; d_read = 1'b0; d_write = 1'b0;
    d_addr = '0; d_wdata = '0; mem_rdata = '0; mem_resp = 1'b0;
    cyc();

    // ---- reset state ----
    check("rst_mem_read",  mem_read,  1'b0);
    check("rst_mem_write", mem_write, 1'b0);
    check("rst_mem_addr",  mem_addr,  32'h0);
    check("rst_mem_wdata", mem_wdata, 64'h0);
    check("rst_i_resp",    i_resp,    1'b0);
    check("rst_d_resp",    d_resp,    1'b0);
    check("rst_i_rdata",   i_rdata,   256'h0);

    // ---- scenario 1: icache read, granted on first edge after reset ----
    reset_n = 1'b1; i_read = 1'b1; i_addr = 32'h0000_0064;
    cyc();
    check("s1_mem_read",  mem_read,  1'b1);
    check("s1_mem_write", mem_write, 1'b0);
    check("s1_mem_addr",  mem_addr,  32'h0000_0060);
    i_read = 1'b0;
    beat(B1); beat(B2); beat(B3);
    check("s1_no_early_resp", i_resp, 1'b0);
    check("s1_mem_read_b3",   mem_read, 1'b1);
    beat(B4);
    check("s1_i_resp",    i_resp,   1'b1);
    check("s1_d_resp",    d_resp,   1'b0);
    check("s1_done_rd",   mem_read, 1'b0);
    check("s1_i_rdata",   i_rdata,  line_a);
    check("s1_d_rdata",   d_rdata,  line_a);
    cyc();
    check("s1_i_resp_off", i_resp, 1'b0);

    // ---- scenario 2: dcache writeback ----
    d_write = 1'b1; d_addr = 32'h8000_00A0; d_wdata = pat_p;
    cyc();
    check("s2_mem_write", mem_write, 1'b1);
    check("s2_mem_read",  mem_read,  1'b0);
    check("s2_mem_addr",  mem_addr,  32'h8000_00A0);
    d_write = 1'b0; d_wdata = '0;
    check("s2_wbeat0", mem_wdata, pat_p[63:0]);
    beat(64'h0);
    check("s2_wbeat1", mem_wdata, pat_p[127:64]);
    beat(64'h0);
    check("s2_wbeat2", mem_wdata, pat_p[191:128]);
    beat(64'h0);
    check("s2_wbeat3", mem_wdata, pat_p[255:192]);
    check("s2_wr_held", mem_write, 1'b1);
    beat(64'h0);
    check("s2_d_resp",     d_resp,    1'b1);
    check("s2_i_resp",     i_resp,    1'b0);
    check("s2_wr_low",     mem_write, 1'b0);
    check("s2_rline_kept", i_rdata,   line_a);
    cyc();
    check("s2_d_resp_off", d_resp, 1'b0);

    // ---- scenario 3: tie from reset, dcache first then icache ----
    reset_n = 1'b0;
    cyc();
    check("s3_rst_rdata", d_rdata, 256'h0);
    reset_n = 1'b1;
    i_read = 1'b1; i_addr = 32'h0000_0100;
    d_read = 1'b1; d_addr = 32'h0000_0200;
    cyc();
    check("s3_d_grant_rd",   mem_read, 1'b1);
    check("s3_d_grant_addr", mem_addr, 32'h0000_0200);
    beat(line_d[63:0]); beat(line_d[127:64]); beat(line_d[191:128]); beat(line_d[255:192]);
    check("s3_d_resp",  d_resp,  1'b1);
    check("s3_i_resp0", i_resp,  1'b0);
    check("s3_d_rdata", d_rdata, line_d);
    cyc();
    check("s3_no_regrant", mem_read, 1'b0);
    check("s3_d_resp_off", d_resp,   1'b0);
    check("s3_i_resp_idle", i_resp,  1'b0);
    cyc();
    check("s3_i_grant_rd",   mem_read, 1'b1);
    check("s3_i_grant_addr", mem_addr, 32'h0000_0100);
    i_read = 1'b0; d_read = 1'b0;
    beat(line_i[63:0]); beat(line_i[127:64]); beat(line_i[191:128]); beat(line_i[255:192]);
    check("s3_i_resp",  i_resp,  1'b1);
    check("s3_d_resp1", d_resp,  1'b0);
    check("s3_i_rdata", i_rdata, line_i);
    cyc();
    check("s3_i_resp_off", i_resp, 1'b0);

    // ---- scenario 4: async reset mid-burst, then restart from beat 0 ----
    i_read = 1'b1; i_addr = 32'h0000_0040;
    cyc();
    check("s4_grant", mem_read, 1'b1);
    i_read = 1'b0;
    beat(64'hBAD0_0000_0000_0001); beat(64'hBAD0_0000_0000_0002);
    #2 reset_n = 1'b0;
    #1;
    check("s4_async_rd",    mem_read, 1'b0);
    check("s4_async_addr",  mem_addr, 32'h0);
    check("s4_async_rdata", i_rdata,  256'h0);
    @(negedge clk);
    reset_n = 1'b1; i_read = 1'b1; i_addr = 32'h0000_0040;
    cyc();
    check("s4_regrant_addr", mem_addr, 32'h0000_0040);
    i_read = 1'b0;
    beat(line_r[63:0]); beat(line_r[127:64]); beat(line_r[191:128]); beat(line_r[255:192]);
    check("s4_i_resp",  i_resp,  1'b1);
    check("s4_i_rdata", i_rdata, line_r);
    cyc();

    // ---- scenario 5: stray mem_resp in IDLE, then read+write is a write ----
    beat(64'hFFFF_FFFF_FFFF_FFFF);
    check("s5_stray_rd",    mem_read,  1'b0);
    check("s5_stray_wr",    mem_write, 1'b0);
    check("s5_stray_resp",  i_resp | d_resp, 1'b0);
    check("s5_stray_rdata", i_rdata,   line_r);
    d_read = 1'b1; d_write = 1'b1; d_addr = 32'h0000_001F; d_wdata = pat_q;
    cyc();
    check("s5_rw_write", mem_write, 1'b1);
    check("s5_rw_read",  mem_read,  1'b0);
    check("s5_rw_addr",  mem_addr,  32'h0000_0000);
    d_read = 1'b0; d_write = 1'b0;
    check("s5_wbeat0", mem_wdata, pat_q[63:0]);
    beat(64'h0);
    check("s5_wbeat1", mem_wdata, pat_q[127:64]);
    beat(64'h0);
    check("s5_wbeat2", mem_wdata, pat_q[191:128]);
    beat(64'h0);
    check("s5_wbeat3", mem_wdata, pat_q[255:192]);
    beat(64'h0);
    check("s5_d_resp",     d_resp,  1'b1);
    check("s5_rline_kept", d_rdata, line_r);
    cyc();
    check("s5_d_resp_off", d_resp,    1'b0);
    check("s5_idle_wr",    mem_write, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mem_burst_arbiter.md
MEM_BURST_ARBITER -- requirements
Module: mem_burst_arbiter

Interface
REQ-001 SHALL have parameter LINE_W, default 256: cache line width in bits.
REQ-002 SHALL have parameter BURST_W, default 64: memory beat width in bits.
REQ-003 SHALL have parameter BEATS, default 4: beats per line (LINE_W/BURST_W).
REQ-004 SHALL have these ports; clock and reset first:
- clk  in  1  sole clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- i_read  in  1  icache line read request.
- i_addr  in  32  icache line address.
- i_rdata  out  LINE_W  icache read line.
- i_resp  out  1  icache completion pulse.
- d_read  in  1  dcache line read request.
- d_write  in  1  dcache line writeback request.
- d_addr  in  32  dcache line address.
- d_wdata  in  LINE_W  dcache writeback line.
- d_rdata  out  LINE_W  dcache read line.
- d_resp  out  1  dcache completion pulse.
- mem_read  out  1  burst read to physical memory.
- mem_write  out  1  burst write to physical memory.
- mem_addr  out  32  burst address.
- mem_wdata  out  BURST_W  write beat.
- mem_rdata  in  BURST_W  read beat.
- mem_resp  in  1  beat valid/accepted.

Function
REQ-005 SHALL implement states IDLE, I_RD, D_RD, D_WR, DONE.
REQ-006 In IDLE, SHALL grant a pending request; if icache and dcache both request, SHALL grant the port not granted last (the last-grant flag resets to icache, so dcache wins the first tie).
REQ-007 d_read and d_write both high SHALL be treated as a write (D_WR).
REQ-008 SHALL latch the granted address at grant; mem_addr SHALL be {addr[31:5], 5'b0} for the whole burst.
REQ-009 mem_read SHALL be high throughout I_RD/D_RD, and mem_write throughout D_WR; both SHALL be low in IDLE and DONE.
REQ-010 On each mem_resp in I_RD/D_RD, SHALL store mem_rdata into beat slot [cnt*BURST_W +: BURST_W] and increment the 2-bit beat counter cnt.
REQ-011 In D_WR, SHALL latch d_wdata at grant; mem_wdata SHALL be beat cnt, advancing on each mem_resp.
REQ-012 On the mem_resp of beat BEATS-1, SHALL go to DONE and clear cnt (wrap to 0).
REQ-013 DONE SHALL last exactly one cycle, pulse i_resp or d_resp for the granted port only, then return to IDLE.
REQ-014 The stored line SHALL drive both i_rdata and d_rdata and SHALL hold until the next read burst overwrites it.
REQ-015 Latency SHALL be: grant one cycle after the request is seen in IDLE; resp the cycle after the last mem_resp.
REQ-016 mem_resp in IDLE or DONE SHALL be ignored.
REQ-017 A request deasserted mid-burst SHALL NOT abort the burst: the burst completes and resp still pulses.
REQ-018 A request held during DONE SHALL NOT be regranted in that cycle; it is re-evaluated in IDLE.

Reset
REQ-019 reset_n low SHALL immediately force IDLE, cnt=0, last-grant=icache, line buffer=0, and all outputs 0, including mid-burst.
REQ-020 After reset_n rises, SHALL accept requests on the first clock edge.

Structure
REQ-021 The state enum and LINE_W/BURST_W/BEATS constants SHALL live in a shared package (burst_types) next to rv32i_types.
REQ-022 The beat counter and line assembly/disassembly register SHALL be one sub-module, line_burst_buffer; arbitration and the FSM SHALL remain in mem_burst_arbiter.

Verification
REQ-023 The bench SHALL cover these directed scenarios:
- i_read, i_addr=0x0000_0064; beats 0x11..,0x22..,0x33..,0x44.. -> mem_addr=0x60; i_rdata={44,33,22,11} beats; one i_resp pulse.
- d_write, d_addr=0x8000_00A0, d_wdata=pattern P -> mem_write high for 4 mem_resp; mem_wdata = P[63:0] through P[255:192] in order; d_resp one cycle after beat 3.
- i_read and d_read together from reset -> dcache served first, then icache; exactly two resp pulses, in that order.
- reset_n low after beat 2 of a read -> outputs 0 asynchronously; the next request restarts from beat 0.
- Stray mem_resp in IDLE, and d_read+d_write together -> no state change for the former; write burst for the latter.
